// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encodings, owner codes and line-offset default shared by the miss arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wr_state_e;
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;
  localparam int LINE_OFF_DEF = 4;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: 4-bit saturating wait counter with a threshold flag.
module arb_starve_cnt #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 4'd0 : (inc_i && cnt_q != 4'hf) ? cnt_q + 4'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 4'd0 : cnt_d;
  assign hit_o = int'(cnt_q) >= LIMIT;
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: schedules ICache/DCache misses onto the bridge read and write ports,
// routes returned beats by owner and holds same-line opposite-direction transfers.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int LINE_OFF = LINE_OFF_DEF
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         i_rd_req,
  input  logic [1:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  input  logic         d_rd_req,
  input  logic [1:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  input  logic         d_wr_req,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  input  logic         d_uncache_store,
  output logic         d_wr_rdy,
  output logic         m_rd_req,
  output logic [1:0]   m_rd_type,
  output logic [31:0]  m_rd_addr,
  input  logic         m_rd_rdy,
  input  logic         m_ret_valid,
  input  logic         m_ret_last,
  output logic         m_wr_req,
  output logic [31:0]  m_wr_addr,
  output logic [3:0]   m_wr_wstrb,
  output logic [127:0] m_wr_data,
  output logic         m_uncache_store,
  input  logic         m_wr_rdy,
  input  logic         m_wr_done
);
  localparam int LW = 32 - LINE_OFF;
  rd_state_e rd_q, rd_d;
  wr_state_e wr_q, wr_d;
  logic rd_own_q, rd_own_d, wr_uc_q, wr_uc_d;
  logic [1:0] rd_type_q, rd_type_d;
  logic [31:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [3:0] wr_strb_q, wr_strb_d;
  logic [127:0] wr_data_q, wr_data_d;
  logic starve_hit, wr_acc, i_ok, d_ok, i_win, rd_idle, wr_busy;
  logic [LW-1:0] i_line, d_line, w_line, wq_line, rq_line;
  assign i_line  = i_rd_addr[31:LINE_OFF];
  assign d_line  = d_rd_addr[31:LINE_OFF];
  assign w_line  = d_wr_addr[31:LINE_OFF];
  assign wq_line = wr_addr_q[31:LINE_OFF];
  assign rq_line = rd_addr_q[31:LINE_OFF];
  assign wr_busy = wr_q != W_IDLE;
  assign d_wr_rdy = !areset && !wr_busy && !(rd_q != R_IDLE && w_line == rq_line);
  assign wr_acc = d_wr_req && d_wr_rdy;
  // A read is held against the in-flight write line and against a write accepted this very cycle.
  assign i_ok = i_rd_req && !(wr_busy && i_line == wq_line) && !(wr_acc && i_line == w_line);
  assign d_ok = d_rd_req && !(wr_busy && d_line == wq_line) && !(wr_acc && d_line == w_line);
  assign i_win = i_ok && (!d_ok || starve_hit);
  assign rd_idle = !areset && rd_q == R_IDLE;
  assign i_rd_rdy = rd_idle && i_win;
  assign d_rd_rdy = rd_idle && d_ok && !i_win;
  arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk(aclk), .rst(areset), .inc_i(i_rd_req), .clr_i(i_rd_rdy || !i_rd_req), .hit_o(starve_hit)
  );
  always_comb begin
    rd_d = rd_q;
    rd_own_d = rd_own_q;
    rd_type_d = rd_type_q;
    rd_addr_d = rd_addr_q;
    if (i_rd_rdy || d_rd_rdy) begin
      rd_d = R_REQ;
      rd_own_d = d_rd_rdy ? OWNER_D : OWNER_I;
      rd_type_d = d_rd_rdy ? d_rd_type : i_rd_type;
      rd_addr_d = d_rd_rdy ? d_rd_addr : i_rd_addr;
    end
    if (rd_q == R_REQ && m_rd_rdy) rd_d = R_DATA;
    if (rd_q == R_DATA && m_ret_valid && m_ret_last) rd_d = R_IDLE;
  end
  always_comb begin
    wr_d = wr_q;
    wr_addr_d = wr_addr_q;
    wr_strb_d = wr_strb_q;
    wr_data_d = wr_data_q;
    wr_uc_d = wr_uc_q;
    if (wr_acc) begin
      wr_d = W_REQ;
      wr_addr_d = d_wr_addr;
      wr_strb_d = d_wr_wstrb;
      wr_data_d = d_wr_data;
      wr_uc_d = d_uncache_store;
    end
    if (wr_q == W_REQ && m_wr_rdy) wr_d = W_WAIT;
    if (wr_q == W_WAIT && m_wr_done) wr_d = W_IDLE;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_q <= R_IDLE;
      wr_q <= W_IDLE;
      rd_own_q <= OWNER_I;
      rd_type_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_strb_q <= '0;
      wr_data_q <= '0;
      wr_uc_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      rd_own_q <= rd_own_d;
      rd_type_q <= rd_type_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_strb_q <= wr_strb_d;
      wr_data_q <= wr_data_d;
      wr_uc_q <= wr_uc_d;
    end
  end
  // Outputs are forced low while reset is asserted, before the first reset edge lands.
  assign m_rd_req = !areset && rd_q == R_REQ;
  assign m_rd_type = areset ? '0 : rd_type_q;
  assign m_rd_addr = areset ? '0 : rd_addr_q;
  assign m_wr_req = !areset && wr_q == W_REQ;
  assign m_wr_addr = areset ? '0 : wr_addr_q;
  assign m_wr_wstrb = areset ? '0 : wr_strb_q;
  assign m_wr_data = areset ? '0 : wr_data_q;
  assign m_uncache_store = !areset && wr_uc_q;
  assign i_ret_valid = !areset && m_ret_valid && rd_q == R_DATA && rd_own_q == OWNER_I;
  assign d_ret_valid = !areset && m_ret_valid && rd_q == R_DATA && rd_own_q == OWNER_D;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized and directed traffic against a transaction-level reference model
// with a bridge responder and a scoreboard that checks captured bridge requests.
module tb_mem_req_arbiter;
  logic aclk = 1'b0, areset = 1'b1;
  logic i_rd_req, i_rd_rdy, i_ret_valid, d_rd_req, d_rd_rdy, d_ret_valid;
  logic [1:0] i_rd_type, d_rd_type, m_rd_type;
  logic [31:0] i_rd_addr, d_rd_addr, d_wr_addr, m_rd_addr, m_wr_addr;
  logic d_wr_req, d_uncache_store, d_wr_rdy, m_rd_req, m_rd_rdy, m_ret_valid, m_ret_last;
  logic [3:0] d_wr_wstrb, m_wr_wstrb;
  logic [127:0] d_wr_data, m_wr_data;
  logic m_wr_req, m_uncache_store, m_wr_rdy, m_wr_done;
  always #5 aclk = ~aclk;
  mem_req_arbiter dut (
    .aclk(aclk), .areset(areset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data),
    .d_uncache_store(d_uncache_store), .d_wr_rdy(d_wr_rdy),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data),
    .m_uncache_store(m_uncache_store), .m_wr_rdy(m_wr_rdy), .m_wr_done(m_wr_done)
  );
  int total = 0, bad = 0;
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {logic [31:0] a; logic [1:0] t;} rd_t;
  typedef struct {logic [31:0] a; logic [3:0] s; logic [127:0] d; logic u;} wr_t;
  rd_t exp_rd_q[$];
  wr_t exp_wr_q[$];
  int rd_ph = 0, wr_ph = 0, starve = 0, beats_seen = 0;
  logic [27:0] rd_line = '0, wr_line = '0;
  logic rd_own = 1'b0;
  logic i_acc = 0, d_acc = 0, w_acc = 0, rd_hs = 0, wr_hs = 0, beat = 0;
  function automatic logic hz(logic [31:0] a, logic wa);
    return (wr_ph != 0 && a[31:4] == wr_line) || (wa && a[31:4] == d_wr_addr[31:4]);
  endfunction
  // reference model: phases 0 idle, 1 request, 2 data/wait
  always @(negedge aclk) begin
    logic e_wrdy, wacc_e, iok, dok, ig, dg;
    i_acc = i_rd_req && i_rd_rdy;
    d_acc = d_rd_req && d_rd_rdy;
    w_acc = d_wr_req && d_wr_rdy;
    rd_hs = m_rd_req && m_rd_rdy;
    wr_hs = m_wr_req && m_wr_rdy;
    beat = m_ret_valid;
    if (areset) begin
      chk("rst_ctrl", {i_rd_rdy, d_rd_rdy, d_wr_rdy, m_rd_req, m_wr_req, i_ret_valid, d_ret_valid, m_uncache_store}, 0);
      chk("rst_fields", {m_rd_addr, m_rd_type, m_wr_addr, m_wr_wstrb}, 0);
      chk("rst_wdata", m_wr_data, 0);
      rd_ph = 0; wr_ph = 0; starve = 0; rd_own = 0;
      exp_rd_q.delete(); exp_wr_q.delete();
    end else begin
      e_wrdy = wr_ph == 0 && !(rd_ph != 0 && d_wr_addr[31:4] == rd_line);
      wacc_e = d_wr_req && e_wrdy;
      iok = i_rd_req && !hz(i_rd_addr, wacc_e);
      dok = d_rd_req && !hz(d_rd_addr, wacc_e);
      dg = rd_ph == 0 && dok && !(starve >= 8 && iok);
      ig = rd_ph == 0 && iok && !dg;
      chk("i_rd_rdy", i_rd_rdy, ig);
      chk("d_rd_rdy", d_rd_rdy, dg);
      chk("d_wr_rdy", d_wr_rdy, e_wrdy);
      chk("m_rd_req", m_rd_req, rd_ph == 1);
      chk("m_wr_req", m_wr_req, wr_ph == 1);
      chk("i_ret_valid", i_ret_valid, m_ret_valid && rd_ph == 2 && !rd_own);
      chk("d_ret_valid", d_ret_valid, m_ret_valid && rd_ph == 2 && rd_own);
      starve = (ig || !i_rd_req) ? 0 : (starve < 15 ? starve + 1 : 15);
      case (rd_ph)
        0: if (ig || dg) begin
          exp_rd_q.push_back('{a: dg ? d_rd_addr : i_rd_addr, t: dg ? d_rd_type : i_rd_type});
          rd_line = dg ? d_rd_addr[31:4] : i_rd_addr[31:4];
          rd_own = dg;
          rd_ph = 1;
        end
        1: if (m_rd_rdy) rd_ph = 2;
        default: if (m_ret_valid) begin
          beats_seen++;
          if (m_ret_last) rd_ph = 0;
        end
      endcase
      case (wr_ph)
        0: if (wacc_e) begin
          exp_wr_q.push_back('{a: d_wr_addr, s: d_wr_wstrb, d: d_wr_data, u: d_uncache_store});
          wr_line = d_wr_addr[31:4];
          wr_ph = 1;
        end
        1: if (m_wr_rdy) wr_ph = 2;
        default: if (m_wr_done) wr_ph = 0;
      endcase
    end
  end
  // scoreboard monitor: pops on each new bridge request and checks fields stay stable
  rd_t cur_rd = '{a: '0, t: '0};
  wr_t cur_wr = '{a: '0, s: '0, d: '0, u: 1'b0};
  logic prev_rq = 1'b0, prev_wq = 1'b0;
  always @(negedge aclk) begin
    if (m_rd_req && !prev_rq) begin
      if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else cur_rd = exp_rd_q.pop_front();
    end
    if (m_rd_req) begin
      chk("m_rd_addr", m_rd_addr, cur_rd.a);
      chk("m_rd_type", m_rd_type, cur_rd.t);
    end
    if (m_wr_req && !prev_wq) begin
      if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else cur_wr = exp_wr_q.pop_front();
    end
    if (m_wr_req) begin
      chk("m_wr_addr", m_wr_addr, cur_wr.a);
      chk("m_wr_wstrb", m_wr_wstrb, cur_wr.s);
      chk("m_wr_data", m_wr_data, cur_wr.d);
      chk("m_uncache_store", m_uncache_store, cur_wr.u);
    end
    prev_rq = m_rd_req;
    prev_wq = m_wr_req;
  end
  // bridge responder; stale read beats keep flowing across a reset
  int beats_left = 0, blen = 4, wpend = 0;
  bit rand_len = 0;
  initial begin
    m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0; m_wr_rdy = 0; m_wr_done = 0;
    forever begin
      @(posedge aclk); #1;
      if (rd_hs) beats_left = rand_len ? int'($urandom_range(1, 4)) : blen;
      else if (beat && beats_left > 0) beats_left--;
      if (areset) wpend = 0;
      else if (wr_hs) wpend = int'($urandom_range(1, 4));
      else if (wpend > 0) wpend--;
      m_wr_done = wpend == 1;
      m_wr_rdy = m_wr_req && wpend == 0 && $urandom_range(0, 1) == 1;
      m_rd_rdy = m_rd_req && beats_left == 0 && $urandom_range(0, 1) == 1;
      m_ret_valid = beats_left > 0 && $urandom_range(0, 3) != 0;
      m_ret_last = beats_left == 1;
    end
  end
  task automatic step();
    @(posedge aclk); #1;
    if (i_acc) i_rd_req = 0;
    if (d_acc) d_rd_req = 0;
    if (w_acc) d_wr_req = 0;
  endtask
  task automatic settle(string nm);
    int k = 0;
    while (k < 200 && (rd_ph != 0 || wr_ph != 0 || beats_left != 0)) begin step(); k++; end
    chk(nm, k < 200, 1);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_2040;
      1: return 32'h0000_204C;
      2: return 32'h0000_2048;
      3: return 32'h0000_3000;
      4: return 32'h1C00_0000;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction
  initial begin
    int base;
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0; d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    d_wr_req = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0; d_uncache_store = 0;
    repeat (3) step();
    areset = 0;
    step();
    i_rd_addr = 32'h1C00_0000; d_rd_addr = 32'h0000_1000; i_rd_type = 2'b10; d_rd_type = 2'b10;
    i_rd_req = 1; d_rd_req = 1;
    for (int k = 0; k < 100 && i_rd_req; k++) step();
    chk("s1_i_granted", i_rd_req, 0);
    settle("s1_settle");
    i_rd_addr = 32'h1C00_0100; i_rd_req = 1;
    for (int k = 0; k < 300 && i_rd_req; k++) begin
      if (!d_rd_req) begin d_rd_req = 1; d_rd_addr = 32'h0000_1000 + ($urandom_range(0, 15) << 4); end
      step();
    end
    chk("s2_starve_grant", i_rd_req, 0);
    d_rd_req = 0;
    settle("s2_settle");
    d_wr_addr = 32'h0000_2040; d_wr_wstrb = 4'hf; d_wr_data = {4{$urandom}}; d_uncache_store = 0; d_wr_req = 1;
    for (int k = 0; k < 50 && d_wr_req; k++) step();
    chk("s3_wr_accept", d_wr_req, 0);
    d_rd_addr = 32'h0000_204C; d_rd_req = 1;
    for (int k = 0; k < 100 && d_rd_req; k++) step();
    chk("s3_rd_after_wr", d_rd_req, 0);
    settle("s3_settle");
    d_wr_addr = 32'h0000_3004; d_wr_wstrb = 4'b0010; d_wr_data = {96'd0, $urandom}; d_uncache_store = 1; d_wr_req = 1;
    for (int k = 0; k < 50 && d_wr_req; k++) step();
    chk("s4_uc_accept", d_wr_req, 0);
    settle("s4_settle");
    chk("s4_wr_rdy_back", d_wr_rdy, 1);
    d_uncache_store = 0;
    base = beats_seen;
    d_rd_addr = 32'h0000_5000; d_rd_req = 1;
    for (int k = 0; k < 100 && beats_seen < base + 2; k++) step();
    chk("s5_two_beats", beats_seen >= base + 2, 1);
    areset = 1;
    step();
    areset = 0;
    repeat (10) step();
    settle("s5_settle");
    rand_len = 1;
    for (int k = 0; k < 3000; k++) begin
      if (!i_rd_req && $urandom_range(0, 2) == 0) begin
        i_rd_req = 1; i_rd_addr = pick(); i_rd_type = 2'($urandom);
      end
      if (!d_rd_req && $urandom_range(0, 2) == 0) begin
        d_rd_req = 1; d_rd_addr = pick(); d_rd_type = 2'($urandom);
      end
      if (!d_wr_req && $urandom_range(0, 3) == 0) begin
        d_wr_req = 1; d_wr_addr = pick(); d_wr_wstrb = 4'($urandom);
        d_wr_data = {4{$urandom}}; d_uncache_store = 1'($urandom);
      end
      step();
    end
    i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
    settle("rand_settle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Schedules ICache and DCache miss traffic onto the single read port and single write port of the AXI transfer bridge. It grants one outstanding read at a time, with DCache priority and an ICache anti-starvation override, and routes returned beats to the owning cache. It also holds a read or write that targets the same 16-byte line as an in-flight opposite-direction transfer. It sits between the two caches and the bridge. Bridge rdata and rlast fan out to both caches directly; this block generates only the per-cache valids.

## Interface
- STARVE_LIMIT, 8: cycles of ICache waiting that force an ICache grant; range 1..15.
- LINE_OFF, 4: byte-offset bits ignored in line-address compare.
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- i_rd_req  in  1  ICache read request
- i_rd_type  in  2  ICache read size code
- i_rd_addr  in  32  ICache read address
- i_rd_rdy  out  1  ICache read accepted this cycle
- i_ret_valid  out  1  current bridge beat belongs to ICache
- d_rd_req  in  1  DCache read request
- d_rd_type  in  2  DCache read size code
- d_rd_addr  in  32  DCache read address
- d_rd_rdy  out  1  DCache read accepted this cycle
- d_ret_valid  out  1  current bridge beat belongs to DCache
- d_wr_req  in  1  DCache write request
- d_wr_addr  in  32  write address
- d_wr_wstrb  in  4  byte strobe for uncached store
- d_wr_data  in  128  write line / word in [31:0]
- d_uncache_store  in  1  single-beat uncached store
- d_wr_rdy  out  1  write slot free; accept on req&rdy
- m_rd_req  out  1  read request to bridge
- m_rd_type  out  2  captured size code
- m_rd_addr  out  32  captured address
- m_rd_rdy  in  1  bridge accepted read
- m_ret_valid  in  1  bridge read beat valid
- m_ret_last  in  1  last beat of burst
- m_wr_req  out  1  write request to bridge
- m_wr_addr  out  32  captured write address
- m_wr_wstrb  out  4  captured strobe
- m_wr_data  out  128  captured write data
- m_uncache_store  out  1  captured uncached flag
- m_wr_rdy  in  1  bridge accepted write
- m_wr_done  in  1  bridge write response (B handshake) complete

## Operation
- Read FSM: R_IDLE -> R_REQ when a read is accepted. R_REQ -> R_DATA on m_rd_rdy. R_DATA -> R_IDLE on m_ret_valid&m_ret_last. Owner bit (0 = I, 1 = D) is captured at accept.
- Grant in R_IDLE only. D wins if d_rd_req and D is not hazarded, unless starve_cnt >= STARVE_LIMIT and i_rd_req and I is not hazarded; then I wins. I wins if D is absent or hazarded. rdy outputs are combinational and 0 outside R_IDLE.
- starve_cnt: 4 bits. Increments, saturating at 15, each cycle i_rd_req=1 and I is not granted. Clears on an I grant or when i_rd_req=0.
- Read hazard: (rd_addr>>LINE_OFF) equals the captured write line while the write FSM is not in W_IDLE, or equals d_wr_addr's line when a write is accepted in the same cycle.
- Write FSM: W_IDLE -> W_REQ on d_wr_req&d_wr_rdy, capturing all write fields. W_REQ -> W_WAIT on m_wr_rdy. W_WAIT -> W_IDLE on m_wr_done. d_wr_rdy = W_IDLE and not (read FSM != R_IDLE and the write line equals the captured read line).
- Return routing: i_ret_valid = m_ret_valid & R_DATA & owner==0. d_ret_valid likewise with owner==1. Beats outside R_DATA are dropped.

## Timing
- Accept at edge N; m_rd_req/m_wr_req is high from N+1 and held with stable fields until the bridge handshake. Next read grant is possible the cycle after the last beat.
- Reads and writes proceed concurrently; simultaneous read and write accepts are legal subject to the hazard rules.
- Reset, including mid-burst: both FSMs idle, starve_cnt=0, owner=0, captured fields 0. All outputs read 0 during reset (rdy gated by areset). Outstanding bridge beats after reset are discarded.

## Structure
- Shared package mem_arb_pkg: read states {R_IDLE,R_REQ,R_DATA}, write states {W_IDLE,W_REQ,W_WAIT}, OWNER_I=0, OWNER_D=1, LINE_OFF default. Sub-module arb_starve_cnt (saturating counter with threshold flag).

## Test plan
- Both reads request in the same cycle, addrs 0x1C000000 (I) and 0x00001000 (D) -> D granted; 4 beats give d_ret_valid x4; I granted the cycle after the last beat.
- D reads back-to-back continuously, I held requesting -> I is granted once starve_cnt reaches 8; the counter then clears.
- Write to 0x00002040 outstanding, D read to 0x0000204C -> d_rd_rdy=0 until m_wr_done; read accepted on the next cycle.
- Uncached store wstrb=4'b0010 -> m_wr_req with m_uncache_store=1 and m_wr_wstrb=4'b0010; d_wr_rdy returns high after m_wr_done.
- areset pulsed in R_DATA after beat 2 -> outputs 0, FSMs idle; beats 3-4 produce no ret_valid.
